// File: rtl/line_buffer_ctrl.sv
// Ping-pong line-buffer controller in front of a 1024x16 dual-port pixel SRAM.
// Latency: a completed line starts streaming 3 cycles after its bankFull flag is seen (FSM, issue, capture).
// Backpressure: none on the pixel input (pixels aimed at a full bank are dropped and flagged);
//   the output is valid/ready, and a 2-entry skid FIFO absorbs the 1-cycle SRAM read latency.
//
// Ports:
//   clock, reset                  single clock, synchronous active-high reset
//   pixelValid/pixelData/startOfLine   incoming pixel stream (startOfLine restarts the line at index 0)
//   sramWeA/sramAddrA/sramDataA   SRAM write port; address and data are 0 when no write happens
//   sramAddrB/sramDataB           SRAM read port; data returns one cycle after the address
//   streamValid/streamData/streamLast/streamReady   drained line words, last word flagged
//   bankFull                      per-bank "line complete, not yet drained"
//   overflow                      sticky, a pixel was dropped because its bank was full

// Small generic synchronous FIFO used as the read-side skid buffer.
// Latency: 1 cycle from push to out_vld; reads the head combinationally.
// Backpressure: the caller must never push when full (count == DEPTH).
module lb_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_vld,
  input  logic [WIDTH-1:0]           in_dat,
  input  logic                       out_rdy,
  output logic                       out_vld,
  output logic [WIDTH-1:0]           out_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign out_vld = (count_q != '0);
  assign out_dat = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign push    = in_vld;
  assign pop     = out_rdy & out_vld;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// Top level: write-side bank/line tracking, read FSM, skid FIFO.
// Latency: write is combinational to SRAM port A; read words appear 3 cycles after bankFull.
// Backpressure: streamReady low stalls issue once the skid FIFO plus in-flight read reach 2.
module line_buffer_ctrl #(
  parameter int LINE_WIDTH = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixelValid,
  input  logic [15:0] pixelData,
  input  logic        startOfLine,
  output logic        sramWeA,
  output logic [9:0]  sramAddrA,
  output logic [15:0] sramDataA,
  output logic [9:0]  sramAddrB,
  input  logic [15:0] sramDataB,
  output logic        streamValid,
  output logic [15:0] streamData,
  output logic        streamLast,
  input  logic        streamReady,
  output logic [1:0]  bankFull,
  output logic        overflow
);
  localparam logic [8:0] LAST_IDX = 9'(LINE_WIDTH - 1);
  localparam logic [9:0] LINE_LEN = 10'(LINE_WIDTH);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_t;

  // Write-side state
  logic       wr_bank_q, wr_bank_d;
  logic [8:0] wr_count_q, wr_count_d;
  logic [1:0] bank_full_q, bank_full_d;
  logic       overflow_q, overflow_d;

  // Read-side state
  rd_state_t  state_q, state_d;
  logic       rd_bank_q, rd_bank_d;
  logic [9:0] rd_count_q, rd_count_d;
  logic       in_flight_q, in_flight_d;
  logic       in_flight_last_q, in_flight_last_d;

  // Write-side combinational
  logic       wr_accept;
  logic [8:0] wr_idx;
  logic       wr_line_done;

  // Read-side combinational
  logic        pop;
  logic        rd_done;
  logic [2:0]  occupancy;
  logic        rd_issue;
  logic        skid_vld;
  logic [16:0] skid_head;
  logic [1:0]  skid_count;

  // ---------------- write side ----------------
  always_comb begin
    wr_accept    = pixelValid & ~reset & ~bank_full_q[wr_bank_q];
    // A startOfLine pixel restarts the line, silently discarding any partial line.
    wr_idx       = startOfLine ? 9'd0 : wr_count_q;
    wr_line_done = wr_accept & (wr_idx == LAST_IDX);

    sramWeA   = wr_accept;
    sramAddrA = wr_accept ? {wr_bank_q, wr_idx} : 10'd0;
    sramDataA = wr_accept ? pixelData : 16'd0;

    wr_count_d = wr_count_q;
    wr_bank_d  = wr_bank_q;
    if (wr_accept) begin
      if (wr_line_done) begin
        wr_count_d = 9'd0;
        wr_bank_d  = ~wr_bank_q;
      end else begin
        wr_count_d = wr_idx + 9'd1;
      end
    end

    overflow_d = overflow_q | (pixelValid & ~reset & bank_full_q[wr_bank_q]);
  end

  // ---------------- read side ----------------
  always_comb begin
    pop     = skid_vld & streamReady;
    rd_done = pop & skid_head[16];

    // Words that will sit in the skid FIFO after this edge; issuing now adds one more
    // a cycle later, so issue only while that stays within the 2 FIFO entries.
    occupancy = 3'(skid_count) + 3'(in_flight_q) - 3'(pop);
    rd_issue  = (state_q == ST_STREAM) & (rd_count_q < LINE_LEN) & (occupancy < 3'd2);

    sramAddrB = rd_issue ? {rd_bank_q, rd_count_q[8:0]} : 10'd0;

    state_d    = state_q;
    rd_bank_d  = rd_bank_q;
    rd_count_d = rd_count_q;
    case (state_q)
      ST_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d    = ST_STREAM;
          rd_count_d = 10'd0;
        end
      end
      ST_STREAM: begin
        if (rd_issue) rd_count_d = rd_count_q + 10'd1;
        // The bank is released only once the consumer has taken its final word.
        if (rd_done) begin
          state_d   = ST_IDLE;
          rd_bank_d = ~rd_bank_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_flight_d      = rd_issue;
    in_flight_last_d = rd_issue & (rd_count_q == LINE_LEN - 10'd1);

    // Set and clear always target different banks: the writer only completes a
    // non-full bank while the reader only frees a full one.
    bank_full_d = bank_full_q;
    if (rd_done)      bank_full_d[rd_bank_q] = 1'b0;
    if (wr_line_done) bank_full_d[wr_bank_q] = 1'b1;
  end

  // Skid FIFO carries {last, data}; SRAM data for an issue made last cycle is pushed now.
  lb_fifo #(
    .WIDTH (17),
    .DEPTH (2)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (in_flight_q),
    .in_dat  ({in_flight_last_q, sramDataB}),
    .out_rdy (streamReady),
    .out_vld (skid_vld),
    .out_dat (skid_head),
    .count   (skid_count)
  );

  assign streamValid = skid_vld;
  assign streamData  = skid_head[15:0];
  assign streamLast  = skid_head[16];
  assign bankFull    = bank_full_q;
  assign overflow    = overflow_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_bank_q        <= 1'b0;
      wr_count_q       <= 9'd0;
      bank_full_q      <= 2'b00;
      overflow_q       <= 1'b0;
      state_q          <= ST_IDLE;
      rd_bank_q        <= 1'b0;
      rd_count_q       <= 10'd0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
    end else begin
      wr_bank_q        <= wr_bank_d;
      wr_count_q       <= wr_count_d;
      bank_full_q      <= bank_full_d;
      overflow_q       <= overflow_d;
      state_q          <= state_d;
      rd_bank_q        <= rd_bank_d;
      rd_count_q       <= rd_count_d;
      in_flight_q      <= in_flight_d;
      in_flight_last_q <= in_flight_last_d;
    end
  end
endmodule
